// File: rtl/game_ctrl.sv
// game_ctrl: game sequencing for the four-tile swap puzzle (load, swap, count, win detection)
module game_ctrl #(
    parameter int          CNT_W  = 8,
    parameter logic [11:0] SOLVED = 12'b000_001_010_011
) (
    input  logic             clk_d,
    input  logic             rst,
    input  logic [11:0]      board_in,
    input  logic             start,
    input  logic             restart,
    input  logic             swap_req,
    input  logic [1:0]       swap_pos,
    output logic [1:0]       game_status,
    output logic [11:0]      cur_board,
    output logic [CNT_W-1:0] move_cnt,
    output logic             swap_ack,
    output logic             win_pulse,
    output logic             load_err
);
    localparam logic [1:0] CHOSE_BOARD  = 2'b00;
    localparam logic [1:0] GAMING       = 2'b01;
    localparam logic [1:0] GAME_INITIAL = 2'b10;
    localparam logic [1:0] WINNED       = 2'b11;

    logic [2:0]  slot [4];
    logic [2:0]  f0, f1, f2, f3;
    logic [1:0]  nxt;
    logic [11:0] swapped;
    logic        valid, solved;

    assign f0     = board_in[11:9];
    assign f1     = board_in[8:6];
    assign f2     = board_in[5:3];
    assign f3     = board_in[2:0];
    assign nxt    = swap_pos + 2'd1;
    assign solved = cur_board == SOLVED;
    assign valid  = !(f0[2] | f1[2] | f2[2] | f3[2]) && f0 != f1 && f0 != f2 && f0 != f3
                    && f1 != f2 && f1 != f3 && f2 != f3;

    always_comb begin
        swapped = cur_board;
        for (int i = 0; i < 4; i++) slot[i] = cur_board[11-3*i -: 3];
        for (int k = 0; k < 4; k++)
            swapped[11-3*k -: 3] = (2'(k) == swap_pos) ? slot[nxt] :
                                   (2'(k) == nxt) ? slot[swap_pos] : slot[k];
    end

    always_ff @(posedge clk_d) begin
        if (rst) begin
            game_status <= CHOSE_BOARD;
            cur_board   <= SOLVED;
            move_cnt    <= '0;
            swap_ack    <= 1'b0;
            win_pulse   <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            swap_ack  <= 1'b0;
            win_pulse <= 1'b0;
            load_err  <= 1'b0;
            if (game_status == CHOSE_BOARD) begin
                if (start && valid) begin
                    cur_board   <= board_in;
                    move_cnt    <= '0;
                    game_status <= GAME_INITIAL;
                end
                load_err <= start && !valid;
            end else if (restart) begin
                game_status <= CHOSE_BOARD;
            end else if (game_status != WINNED) begin
                if (solved) begin
                    game_status <= WINNED;
                    win_pulse   <= 1'b1;
                end else if (game_status == GAME_INITIAL) begin
                    game_status <= GAMING;
                end else if (swap_req) begin
                    cur_board <= swapped;
                    move_cnt  <= &move_cnt ? move_cnt : move_cnt + 1'b1;
                    swap_ack  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed plus random stimulus against a tile-array reference model
module tb_game_ctrl;
    logic clk_d = 1'b0;
    always #5 clk_d = ~clk_d;

    logic        rst, start, restart, swap_req;
    logic [1:0]  swap_pos;
    logic [11:0] board_in;
    logic [1:0]  game_status;
    logic [11:0] cur_board;
    logic [1:0]  move_cnt;
    logic        swap_ack, win_pulse, load_err;

    game_ctrl #(.CNT_W(2)) dut (
        .clk_d(clk_d), .rst(rst), .board_in(board_in), .start(start), .restart(restart),
        .swap_req(swap_req), .swap_pos(swap_pos), .game_status(game_status),
        .cur_board(cur_board), .move_cnt(move_cnt), .swap_ack(swap_ack),
        .win_pulse(win_pulse), .load_err(load_err)
    );

    int tests = 0, fails = 0, acks = 0;
    // model status uses the external code: 0 choose, 1 gaming, 2 initial, 3 won
    int m_st, m_cnt;
    int m_b [4];
    bit m_ack, m_win, m_err;

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_solved();
        return m_b[0] == 0 && m_b[1] == 1 && m_b[2] == 2 && m_b[3] == 3;
    endfunction

    task automatic model();
        int t [4];
        int seen, q, tmp;
        bit ok;
        m_ack = 0; m_win = 0; m_err = 0;
        if (rst) begin
            m_st = 0; m_cnt = 0;
            for (int i = 0; i < 4; i++) m_b[i] = i;
        end else if (m_st == 0) begin
            if (start) begin
                seen = 0; ok = 1;
                for (int i = 0; i < 4; i++) begin
                    t[i] = int'(board_in >> (9 - 3*i)) & 7;
                    if (t[i] > 3 || seen[t[i]]) ok = 0;
                    seen = seen | (1 << t[i]);
                end
                if (ok) begin
                    m_b = t; m_cnt = 0; m_st = 2;
                end else m_err = 1;
            end
        end else if (restart) begin
            m_st = 0;
        end else if (m_st != 3) begin
            if (m_solved()) begin
                m_st = 3; m_win = 1;
            end else if (m_st == 2) begin
                m_st = 1;
            end else if (swap_req) begin
                q = (int'(swap_pos) + 1) % 4;
                tmp = m_b[swap_pos]; m_b[swap_pos] = m_b[q]; m_b[q] = tmp;
                m_ack = 1;
                m_cnt = m_cnt < 3 ? m_cnt + 1 : 3;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit s, input bit rs, input bit sr, input int p,
                       input logic [11:0] b);
        logic [11:0] exp_b;
        rst = r; start = s; restart = rs; swap_req = sr; swap_pos = 2'(p); board_in = b;
        @(posedge clk_d);
        model();
        #1;
        exp_b = {3'(m_b[0]), 3'(m_b[1]), 3'(m_b[2]), 3'(m_b[3])};
        acks += int'(swap_ack);
        chk("game_status", 12'(game_status), 12'(m_st));
        chk("cur_board", cur_board, exp_b);
        chk("move_cnt", 12'(move_cnt), 12'(m_cnt));
        chk("swap_ack", 12'(swap_ack), 12'(m_ack));
        chk("win_pulse", 12'(win_pulse), 12'(m_win));
        chk("load_err", 12'(load_err), 12'(m_err));
    endtask

    function automatic logic [11:0] rand_perm();
        int a [4];
        int j, tmp;
        for (int i = 0; i < 4; i++) a[i] = i;
        for (int i = 3; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = a[i]; a[i] = a[j]; a[j] = tmp;
        end
        return {3'(a[0]), 3'(a[1]), 3'(a[2]), 3'(a[3])};
    endfunction

    initial begin
        cyc(1, 0, 0, 0, 0, 12'h0);
        chk("reset_board", cur_board, 12'b000_001_010_011);
        cyc(0, 1, 0, 0, 0, 12'b000_010_001_011);
        chk("load_status", 12'(game_status), 12'b10);
        cyc(0, 0, 0, 0, 0, 12'h0);
        chk("gaming_status", 12'(game_status), 12'b01);
        cyc(0, 0, 0, 1, 1, 12'h0);
        chk("swap_result", cur_board, 12'b000_001_010_011);
        cyc(0, 0, 0, 1, 0, 12'h0);
        chk("won_cnt", 12'(move_cnt), 12'd1);
        cyc(0, 0, 0, 0, 0, 12'h0);
        cyc(0, 0, 1, 0, 0, 12'h0);
        cyc(0, 1, 0, 0, 0, 12'b011_001_010_000);
        cyc(0, 0, 0, 0, 0, 12'h0);
        cyc(0, 0, 0, 1, 3, 12'h0);
        chk("wrap_swap", cur_board, 12'b000_001_010_011);
        cyc(0, 0, 0, 0, 0, 12'h0);
        chk("wrap_win", 12'(game_status), 12'b11);
        cyc(0, 0, 1, 0, 0, 12'h0);
        cyc(0, 1, 0, 0, 0, 12'b000_001_001_011);
        chk("dup_err", 12'(load_err), 12'd1);
        cyc(0, 1, 0, 0, 0, 12'b000_001_001_011);
        cyc(0, 0, 0, 0, 0, 12'h0);
        cyc(0, 1, 0, 0, 0, 12'b000_001_010_011);
        cyc(0, 0, 0, 0, 0, 12'h0);
        chk("solved_load_win", 12'(win_pulse), 12'd1);
        cyc(0, 0, 1, 0, 0, 12'h0);
        cyc(0, 1, 0, 0, 0, 12'b001_000_011_010);
        cyc(0, 0, 0, 0, 0, 12'h0);
        acks = 0;
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 12'h0);
        chk("sat_acks", 12'(acks), 12'd5);
        chk("sat_cnt", 12'(move_cnt), 12'd3);
        cyc(0, 0, 1, 1, 2, 12'h0);
        chk("restart_noswap", cur_board, 12'b000_001_011_010);
        cyc(0, 1, 0, 0, 0, 12'b001_000_011_010);
        cyc(0, 0, 0, 0, 0, 12'h0);
        cyc(0, 0, 0, 1, 2, 12'h0);
        cyc(1, 0, 1, 1, 1, 12'h0);
        chk("rst_status", 12'(game_status), 12'b00);
        for (int n = 0; n < 3000; n++)
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1,
                int'($urandom_range(0, 3)),
                $urandom_range(0, 3) != 0 ? rand_perm() : 12'($urandom));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/game_ctrl.md
# game_ctrl

Game-sequencing controller for the four-tile permutation puzzle. It owns the `game_status` state register that gates board selection, and captures the selected 12-bit board as the working board. It applies player swap moves to the working board, counts moves and detects the solved arrangement. Its `game_status` output drives the board-selection block's `game_status` input; its `board_in` input is that block's `out`.

## Interface
Parameters:
- `CNT_W`, default 8: width of the move counter.
- `SOLVED`, default 12'b000_001_010_011: the solved arrangement (tiles 0,1,2,3).

Ports (clock and reset first):
- `clk_d`  input  1  system clock; all state changes on its rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `board_in`  input  12  selected board from the board-selection block; slot0=[11:9], slot1=[8:6], slot2=[5:3], slot3=[2:0].
- `start`  input  1  level, sampled each cycle; request to begin a game with `board_in`.
- `restart`  input  1  abort or finish; return to board selection.
- `swap_req`  input  1  single-cycle move request.
- `swap_pos`  input  2  move operand: swap slot `swap_pos` with slot (`swap_pos`+1) mod 4.
- `game_status`  output  2  00 CHOSE_BOARD, 01 GAMING, 10 GAME_INITIAL, 11 WINNED.
- `cur_board`  output  12  working board, registered.
- `move_cnt`  output  CNT_W  accepted swaps since load, registered.
- `swap_ack`  output  1  one-cycle pulse: swap applied this cycle.
- `win_pulse`  output  1  one-cycle pulse on entry to WINNED.
- `load_err`  output  1  one-cycle pulse: `start` rejected because `board_in` is not a permutation.

## Operation
- Reset values: `game_status`=00, `cur_board`=SOLVED, `move_cnt`=0, `swap_ack`=0, `win_pulse`=0, `load_err`=0.
- `board_in` is valid when all four 3-bit fields are ≤3 and pairwise distinct.
- CHOSE_BOARD:
  - `start` with a valid `board_in`: `cur_board`<=`board_in`, `move_cnt`<=0, go to GAME_INITIAL.
  - `start` with an invalid `board_in`: stay in CHOSE_BOARD and pulse `load_err`; `cur_board` is unchanged.
- GAME_INITIAL: lasts one cycle.
  - If `cur_board`==SOLVED, go to WINNED and pulse `win_pulse`.
  - Otherwise go to GAMING.
- GAMING:
  - If `cur_board`==SOLVED, go to WINNED and pulse `win_pulse`. Any `swap_req` in that cycle is ignored: no ack, no count.
  - Otherwise, on `swap_req`, swap the two addressed slots. Position 3 wraps: slot3 swaps with slot0. Then pulse `swap_ack` and increment `move_cnt`.
  - `move_cnt` saturates at all-ones; `swap_ack` still pulses at saturation.
- WINNED: `cur_board` and `move_cnt` are held.
- `restart` from any non-CHOSE_BOARD state goes to CHOSE_BOARD. `cur_board` and `move_cnt` are held until the next load.
- Priority within a cycle: `rst` > `restart` > win transition > `swap_req`.
- `restart` and `swap_req` in the same cycle: no swap, no ack.
- `start` outside CHOSE_BOARD is ignored. `swap_req` outside GAMING is ignored. `swap_pos` is don't-care without `swap_req`.
- `rst` asserted mid-game restores all reset values on the next edge, regardless of state or pending requests.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Game start: `start` sampled at edge N in CHOSE_BOARD.
  - After N: `game_status`=10, `cur_board` and `move_cnt` loaded.
  - After N+1: `game_status`=01, or 11 with `win_pulse`=1 if the loaded board is solved.
- Swap: `swap_req` sampled at edge M in GAMING.
  - After M: `cur_board` swapped, `move_cnt`+1, `swap_ack`=1.
  - If the result is solved: after M+1, `game_status`=11 and `win_pulse`=1. A `swap_req` sampled at M+1 is ignored.
- Back-to-back swaps are accepted every cycle; throughput is one swap per cycle while unsolved.
- All pulses last exactly one cycle.
- `load_err` is asserted the cycle after the rejected `start`, and re-pulses every cycle `start` is held with an invalid board.

## Test plan
- Reset, then start with `board_in`=000_010_001_011 (0213):
  - Status sequence 00→10→01.
  - `cur_board`=0213, `move_cnt`=0.
- From 0213, `swap_req` with `swap_pos`=1:
  - Next cycle `cur_board`=0123, `swap_ack`=1, `move_cnt`=1.
  - One cycle later `game_status`=11, `win_pulse`=1.
  - A `swap_req` in the intervening cycle gives no ack and `move_cnt` stays 1.
- Wrap-around: board 3120, `swap_pos`=3 → `cur_board`=0123, then WINNED.
- Start with `board_in`=000_001_001_011 (duplicate tile): `load_err` pulses, status stays 00, `cur_board` unchanged.
- Start with a solved board (0123): 00→10→11 with `win_pulse`; `move_cnt`=0.
- Saturation and abort:
  - With `CNT_W`=2, five swaps on 1032 → `move_cnt`=3 and five `swap_ack` pulses.
  - Then `restart` together with `swap_req` → status 00, no swap.
  - Then `rst` mid-GAMING → all outputs return to reset values.
